// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer datapath control: FSM states, tap count, operand codes.
package eq_pkg;

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    INICIO  = 3'd1,
    CARGA   = 3'd2,
    MAC     = 3'd3,
    ESCRIBE = 3'd4,
    GUARDA  = 3'd5,
    RESULT  = 3'd6
  } estado_t;

  localparam int unsigned TAPS = 5;

  localparam logic [2:0] OPND_X  = 3'd0;
  localparam logic [2:0] OPND_X1 = 3'd1;
  localparam logic [2:0] OPND_X2 = 3'd2;
  localparam logic [2:0] OPND_Y1 = 3'd3;
  localparam logic [2:0] OPND_Y2 = 3'd4;

  // Taps at or above this index are feedback terms and get subtracted.
  localparam logic [2:0] TAP_SUB = OPND_Y1;

endpackage

// File: rtl/sig_seccion_activa.sv
// Priority search for the lowest non-bypassed section strictly above sec_act
// (or from the first section when desde_inicio is set).
module sig_seccion_activa
  import eq_pkg::*;
#(
  parameter int unsigned NUM_SECTIONS = 3,
  parameter int unsigned SECW         = 2
) (
  input  logic [NUM_SECTIONS-1:0] byp,
  input  logic                    desde_inicio,
  input  logic [SECW-1:0]         sec_act,
  output logic [SECW-1:0]         sec_sig,
  output logic                    ninguna
);

  always_comb begin
    sec_sig = '0;
    ninguna = 1'b1;
    // Walk downwards so the lowest qualifying index is the last one written.
    for (int i = int'(NUM_SECTIONS) - 1; i >= 0; i--) begin
      if (!byp[i] && (desde_inicio || (i > int'(sec_act)))) begin
        sec_sig = SECW'(i);
        ninguna = 1'b0;
      end
    end
  end

endmodule

// File: rtl/control_cascada_biquad.sv
// Sequencer for one shared MAC over a cascade of DF-I biquad sections and several channels,
// with per-sample section bypass and sticky overrun detection.
module control_cascada_biquad
  import eq_pkg::*;
#(
  parameter int unsigned NUM_SECTIONS = 3,
  parameter int unsigned NUM_CHANNELS = 2,
  localparam int unsigned SECW  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1,
  localparam int unsigned CHW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int unsigned ADDRW = $clog2(NUM_SECTIONS * TAPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    datolisto,
  input  logic [NUM_SECTIONS-1:0] bypass,
  input  logic                    clr_overrun,
  output logic                    busy,
  output logic                    ld_cur,
  output logic                    en_x,
  output logic                    acc_clr,
  output logic                    acc_en,
  output logic                    acc_sub,
  output logic [2:0]              opnd_sel,
  output logic [ADDRW-1:0]        coef_addr,
  output logic [SECW-1:0]         sec,
  output logic [CHW-1:0]          ch,
  output logic                    hist_we,
  output logic                    out_we,
  output logic                    resultadolisto,
  output logic                    overrun
);

  estado_t                 state_q, state_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic [SECW-1:0]         sec_q, sec_d;
  logic [2:0]              tap_q, tap_d;
  logic [NUM_SECTIONS-1:0] byp_q, byp_d;
  logic                    overrun_q, overrun_d;

  logic [SECW-1:0] sec_sig;
  logic            ninguna;

  sig_seccion_activa #(
    .NUM_SECTIONS(NUM_SECTIONS),
    .SECW        (SECW)
  ) u_sig (
    .byp         (byp_q),
    .desde_inicio(state_q == INICIO),
    .sec_act     (sec_q),
    .sec_sig     (sec_sig),
    .ninguna     (ninguna)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ESPERA;
      ch_q      <= '0;
      sec_q     <= '0;
      tap_q     <= '0;
      byp_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      sec_q     <= sec_d;
      tap_q     <= tap_d;
      byp_q     <= byp_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = (state_q != ESPERA);
  assign sec     = sec_q;
  assign ch      = ch_q;
  assign overrun = overrun_q;

  // A sample arriving while busy is dropped; set beats clear.
  assign overrun_d = (datolisto && busy) || (overrun_q && !clr_overrun);

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    sec_d          = sec_q;
    tap_d          = tap_q;
    byp_d          = byp_q;
    ld_cur         = 1'b0;
    en_x           = 1'b0;
    acc_clr        = 1'b0;
    acc_en         = 1'b0;
    acc_sub        = 1'b0;
    opnd_sel       = OPND_X;
    coef_addr      = '0;
    hist_we        = 1'b0;
    out_we         = 1'b0;
    resultadolisto = 1'b0;
    unique case (state_q)
      ESPERA: begin
        if (datolisto) begin
          byp_d   = bypass;
          ch_d    = '0;
          state_d = INICIO;
        end
      end
      INICIO: begin
        ld_cur = 1'b1;
        if (ninguna) begin
          state_d = GUARDA;
        end else begin
          sec_d   = sec_sig;
          state_d = CARGA;
        end
      end
      CARGA: begin
        acc_clr = 1'b1;
        en_x    = 1'b1;
        tap_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_en    = 1'b1;
        opnd_sel  = tap_q;
        acc_sub   = (tap_q >= TAP_SUB);
        coef_addr = ADDRW'(32'(sec_q) * TAPS + 32'(tap_q));
        if (tap_q == 3'(TAPS - 1)) begin
          state_d = ESCRIBE;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      ESCRIBE: begin
        hist_we = 1'b1;
        if (ninguna) begin
          state_d = GUARDA;
        end else begin
          sec_d   = sec_sig;
          state_d = CARGA;
        end
      end
      GUARDA: begin
        out_we = 1'b1;
        if (ch_q == CHW'(NUM_CHANNELS - 1)) begin
          state_d = RESULT;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = INICIO;
        end
      end
      RESULT: begin
        resultadolisto = 1'b1;
        state_d        = ESPERA;
      end
      default: state_d = ESPERA;
    endcase
  end

endmodule

// File: tb/tb_control_cascada_biquad.sv
// Bench for control_cascada_biquad: a schedule model derived from the section/channel rules
// checks every busy cycle, plus directed timing, overrun and reset checks.
module tb_control_cascada_biquad;

  localparam int NS = 3;
  localparam int NC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       datolisto = 1'b0;
  logic [2:0] bypass = '0;
  logic       clr_overrun = 1'b0;
  logic       busy, ld_cur, en_x, acc_clr, acc_en, acc_sub, hist_we, out_we;
  logic       resultadolisto, overrun;
  logic [2:0] opnd_sel;
  logic [3:0] coef_addr;
  logic [1:0] sec;
  logic [0:0] ch;

  // Single-section, single-channel instance.
  logic       dl1 = 1'b0;
  logic [0:0] byp1 = '0;
  logic       busy1, ld1, enx1, clr1, acc1, sub1, hw1, ow1, res1, ovr1;
  logic [2:0] opnd1;
  logic [2:0] addr1;
  logic [0:0] sec1;
  logic [0:0] ch1;

  control_cascada_biquad #(.NUM_SECTIONS(NS), .NUM_CHANNELS(NC)) dut (
    .clk(clk), .reset(reset), .datolisto(datolisto), .bypass(bypass),
    .clr_overrun(clr_overrun), .busy(busy), .ld_cur(ld_cur), .en_x(en_x),
    .acc_clr(acc_clr), .acc_en(acc_en), .acc_sub(acc_sub), .opnd_sel(opnd_sel),
    .coef_addr(coef_addr), .sec(sec), .ch(ch), .hist_we(hist_we), .out_we(out_we),
    .resultadolisto(resultadolisto), .overrun(overrun)
  );

  control_cascada_biquad #(.NUM_SECTIONS(1), .NUM_CHANNELS(1)) dut1 (
    .clk(clk), .reset(reset), .datolisto(dl1), .bypass(byp1),
    .clr_overrun(1'b0), .busy(busy1), .ld_cur(ld1), .en_x(enx1),
    .acc_clr(clr1), .acc_en(acc1), .acc_sub(sub1), .opnd_sel(opnd1),
    .coef_addr(addr1), .sec(sec1), .ch(ch1), .hist_we(hw1), .out_we(ow1),
    .resultadolisto(res1), .overrun(ovr1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic ov = 1'b0;
  logic [31:0] exp_q[$];
  int exp_sec[$];
  int exp_ch[$];
  int res_cyc, hw_cnt, ow_cnt, ow_first, ow_last, mid_addr, acc_cnt, ld_cnt;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(int ld, int en, int clr, int acc, int sub, int opnd,
                                      int addr, int hw, int ow, int res, int bsy);
    return 32'(ld | (en << 1) | (clr << 2) | (acc << 3) | (sub << 4) | (opnd << 5) |
               (addr << 8) | (hw << 13) | (ow << 14) | (res << 15) | (bsy << 16));
  endfunction

  function automatic logic [31:0] obs();
    return {15'd0, busy, resultadolisto, out_we, hist_we, 1'b0, coef_addr, opnd_sel,
            acc_sub, acc_en, acc_clr, en_x, ld_cur};
  endfunction

  // Expected busy-cycle trace: per channel a load, 7 cycles per active section, a store;
  // one result cycle at the end.
  task automatic build(input logic [2:0] mask);
    exp_q.delete(); exp_sec.delete(); exp_ch.delete();
    for (int c = 0; c < NC; c++) begin
      exp_q.push_back(enc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); exp_sec.push_back(-1);
      exp_ch.push_back(c);
      for (int s = 0; s < NS; s++) begin
        if (!mask[s]) begin
          exp_q.push_back(enc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1)); exp_sec.push_back(s);
          exp_ch.push_back(c);
          for (int t = 0; t < 5; t++) begin
            exp_q.push_back(enc(0, 0, 0, 1, int'(t >= 3), t, s * 5 + t, 0, 0, 0, 1));
            exp_sec.push_back(s); exp_ch.push_back(c);
          end
          exp_q.push_back(enc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1)); exp_sec.push_back(s);
          exp_ch.push_back(c);
        end
      end
      exp_q.push_back(enc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1)); exp_sec.push_back(-1);
      exp_ch.push_back(c);
    end
    exp_q.push_back(enc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)); exp_sec.push_back(-1);
    exp_ch.push_back(NC - 1);
  endtask

  // mode: 0 quiet, 1 random, 2 pulses at k=10 and in RESULT, 3 set+clear at k=5, 4 held high
  task automatic do_run(input logic [2:0] mask, input int mode);
    int len;
    logic dl, cl;
    build(mask);
    len = exp_q.size();
    datolisto = 1'b1; bypass = mask; clr_overrun = 1'b0;
    step();
    res_cyc = -1; hw_cnt = 0; ow_cnt = 0; ow_first = -1; ow_last = -1;
    mid_addr = 0; acc_cnt = 0; ld_cnt = 0;
    for (int k = 1; k <= len; k++) begin
      check("outputs", obs(), exp_q[k-1]);
      check("ch", 32'(ch), 32'(exp_ch[k-1]));
      if (exp_sec[k-1] >= 0) check("sec", 32'(sec), 32'(exp_sec[k-1]));
      check("overrun", 32'(overrun), 32'(ov));
      if (resultadolisto && res_cyc < 0) res_cyc = k;
      if (hist_we) hw_cnt++;
      if (ld_cur) ld_cnt++;
      if (acc_en) acc_cnt++;
      if (acc_en && coef_addr >= 4'd5 && coef_addr <= 4'd9) mid_addr++;
      if (out_we) begin
        ow_cnt++;
        if (ow_first < 0) ow_first = k;
        ow_last = k;
      end
      dl = 1'b0; cl = 1'b0;
      case (mode)
        1: begin dl = ($urandom_range(0, 7) == 0); cl = ($urandom_range(0, 5) == 0); end
        2: dl = (k == 10) || (k == len);
        3: begin dl = (k == 5); cl = (k == 5); end
        4: dl = 1'b1;
        default: ;
      endcase
      ov = dl | (ov & ~cl);
      datolisto = dl; clr_overrun = cl; bypass = 3'($urandom);
      step();
    end
    check("idle_after_run", 32'(busy), 32'd0);
    check("overrun_after_run", 32'(overrun), 32'(ov));
  endtask

  task automatic idle(input logic cl);
    datolisto = 1'b0; clr_overrun = cl;
    ov = ov & ~cl;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_overrun", 32'(overrun), 32'(ov));
    clr_overrun = 1'b0;
  endtask

  initial begin
    int r1;
    int a1[$];
    int h1;
    step(); step();
    check("reset_outputs", obs(), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_sec_ch", 32'({sec, ch}), 32'd0);
    reset = 1'b0;
    idle(1'b0);

    // All sections active.
    do_run(3'b000, 0);
    check("full_result_cycle", 32'(res_cyc), 32'd47);
    check("full_hist_we", 32'(hw_cnt), 32'd6);
    check("full_out_we_cnt", 32'(ow_cnt), 32'd2);
    check("full_out_we_first", 32'(ow_first), 32'd23);
    check("full_out_we_last", 32'(ow_last), 32'd46);
    idle(1'b0);

    // Middle section bypassed.
    do_run(3'b010, 0);
    check("b010_result_cycle", 32'(res_cyc), 32'd33);
    check("b010_mid_addr", 32'(mid_addr), 32'd0);
    check("b010_hist_we", 32'(hw_cnt), 32'd4);
    idle(1'b0);

    // Everything bypassed.
    do_run(3'b111, 0);
    check("b111_result_cycle", 32'(res_cyc), 32'd5);
    check("b111_acc_en", 32'(acc_cnt), 32'd0);
    check("b111_ld_cur", 32'(ld_cnt), 32'd2);
    check("b111_out_we", 32'(ow_cnt), 32'd2);
    idle(1'b0);

    // Dropped samples at cycle 10 and in RESULT.
    do_run(3'b000, 2);
    check("drop_result_cycle", 32'(res_cyc), 32'd47);
    check("drop_overrun_set", 32'(overrun), 32'd1);
    idle(1'b0);
    idle(1'b1);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Set and clear together.
    do_run(3'b001, 3);
    check("set_wins", 32'(overrun), 32'd1);
    idle(1'b1);

    // datolisto held high: accepted again right at the first idle cycle.
    do_run(3'b000, 4);
    check("held_overrun", 32'(overrun), 32'd1);
    do_run(3'b000, 0);
    check("held_reaccept", 32'(res_cyc), 32'd47);
    idle(1'b1);

    // Reset in the middle of channel 1 MAC.
    datolisto = 1'b1; bypass = 3'b000;
    step();
    for (int k = 1; k < 27; k++) begin
      datolisto = (k == 3);
      step();
    end
    check("pre_reset_acc_en", 32'(acc_en), 32'd1);
    check("pre_reset_ch", 32'(ch), 32'd1);
    check("pre_reset_overrun", 32'(overrun), 32'd1);
    reset = 1'b1;
    step();
    check("post_reset_outputs", obs(), 32'd0);
    check("post_reset_sec_ch", 32'({sec, ch}), 32'd0);
    check("post_reset_overrun", 32'(overrun), 32'd0);
    ov = 1'b0;
    reset = 1'b0;
    idle(1'b0);
    do_run(3'b000, 0);
    check("post_reset_run", 32'(res_cyc), 32'd47);
    idle(1'b0);

    // Random masks with random dropped samples, clears and bypass noise.
    for (int n = 0; n < 20; n++) begin
      do_run(3'($urandom), 1);
      if ($urandom_range(0, 1) == 0) idle(1'($urandom));
    end
    idle(1'b1);

    // One section, one channel.
    r1 = -1; h1 = 0;
    dl1 = 1'b1;
    step();
    dl1 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (res1 && r1 < 0) r1 = k;
      if (acc1) a1.push_back(int'(addr1));
      if (hw1) h1++;
      check("one_sec", 32'(sec1), 32'd0);
      check("one_ch", 32'(ch1), 32'd0);
      step();
    end
    check("one_result_cycle", 32'(r1), 32'd10);
    check("one_hist_we", 32'(h1), 32'd1);
    check("one_addr_cnt", 32'(a1.size()), 32'd5);
    for (int i = 0; i < a1.size(); i++) check("one_addr", 32'(a1[i]), 32'(i));
    check("one_idle", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_cascada_biquad.md
# control_cascada_biquad

Parametrised control unit for the equalizer's arithmetic datapath. It sequences a single shared multiply-accumulate (MAC) unit over a cascade of `NUM_SECTIONS` direct-form-I biquad sections for `NUM_CHANNELS` audio channels per sample. Sections can be bypassed per sample. The block drives coefficient addresses, operand selects, accumulator and history-register enables, and per-channel output writes. It flags samples that arrive while the unit is still busy.

## Interface
- `NUM_SECTIONS`, default 3: biquad sections per channel, range 1–8.
- `NUM_CHANNELS`, default 2: channels processed per sample, range 1–4.
- `clk` in 1: single clock for the block.
- `reset` in 1: synchronous, active-high reset.
- `datolisto` in 1: new sample set available. Sampled every cycle.
- `bypass` in `NUM_SECTIONS`: per-section skip mask, captured when a sample is accepted.
- `clr_overrun` in 1: clears `overrun`.
- `busy` out 1: high whenever state ≠ ESPERA.
- `ld_cur` out 1: load working register `y_cur` from the sample of channel `ch`.
- `en_x` out 1: load section input register from `y_cur`.
- `acc_clr` out 1: clear accumulator.
- `acc_en` out 1: accumulate one product.
- `acc_sub` out 1: subtract the product instead of adding it (feedback taps).
- `opnd_sel` out 3: operand select. 0 = x, 1 = x1, 2 = x2, 3 = y1, 4 = y2.
- `coef_addr` out clog2(`NUM_SECTIONS`·5): coefficient ROM/RAM address, equal to `sec`·5 + `tap`.
- `sec` out clog2(`NUM_SECTIONS`), min 1: current section index.
- `ch` out clog2(`NUM_CHANNELS`), min 1: current channel index.
- `hist_we` out 1: update the history for (`ch`, `sec`): x2←x1, x1←x, y2←y1, y1←acc; also `y_cur`←acc.
- `out_we` out 1: write `y_cur` to the output register of channel `ch`.
- `resultadolisto` out 1: one-cycle pulse when all channels are done.
- `overrun` out 1: sticky flag for a dropped sample.

## Operation
- Moore FSM. All outputs are decoded from the registered state plus the `ch`, `sec` and `tap` counters.
- Reset value of every output is 0. State is ESPERA.
- **ESPERA:** idle.
  - `datolisto`=1: latch `bypass` into `byp_q`, set `ch`=0, go to INICIO.
- **INICIO:** `ld_cur`=1.
  - Set `sec` to the first non-bypassed section, then go to CARGA.
  - If every section is bypassed, go to GUARDA.
- **CARGA:** `acc_clr`=1, `en_x`=1, `tap`←0, go to MAC.
- **MAC:** `acc_en`=1, `opnd_sel`=`tap`, `acc_sub`=(`tap`≥3), `coef_addr`=`sec`·5+`tap`.
  - `tap`=4: go to ESCRIBE.
  - Otherwise: `tap`++.
- **ESCRIBE:** `hist_we`=1.
  - Another non-bypassed section exists above `sec`: `sec`←that section, go to CARGA.
  - Otherwise: go to GUARDA.
- **GUARDA:** `out_we`=1.
  - `ch`=`NUM_CHANNELS`−1: go to RESULT.
  - Otherwise: `ch`++, go to INICIO.
- **RESULT:** `resultadolisto`=1, go to ESPERA.
- Bypassed sections get no `hist_we` at all, so their history registers are frozen.
- **Overrun:**
  - `datolisto`=1 in any state other than ESPERA sets `overrun` and drops that sample. This includes the RESULT cycle.
  - `clr_overrun` clears the flag.
  - If set and clear occur in the same cycle, set wins.
- `bypass` changes while busy have no effect until the next accepted sample.
- `reset` in any state returns the FSM to ESPERA on the next edge and zeroes all counters and `overrun`. The datapath is left with partial history; that is acceptable.

## Timing
- Acceptance edge E0 is the edge that samples `datolisto`=1 in ESPERA. INICIO occupies the cycle after E0.
- A = number of non-bypassed sections. Busy length L = `NUM_CHANNELS`·(2 + 7·A) + 1 cycles, ending with RESULT.
  - Defaults, A=3: L = 47.
  - A=0, 2 channels: L = 5.
- `resultadolisto` is high only in cycle L after E0.
- ESPERA is re-entered at cycle L+1. A `datolisto` in that cycle is accepted.
- Per active section the sequence is exactly 7 cycles: CARGA, MAC×5, ESCRIBE.
- `datolisto` held high continuously:
  - accepts once;
  - sets `overrun` during busy;
  - accepts again at the first ESPERA cycle.

## Structure
- Shared package `eq_pkg` holds:
  - state encoding: ESPERA, INICIO, CARGA, MAC, ESCRIBE, GUARDA, RESULT (3 bits);
  - `TAPS`=5;
  - operand codes 0–4;
  - the `acc_sub` threshold (3).
- One natural sub-module, `sig_seccion_activa`: combinational priority search for the next non-bypassed section index above a given index, plus a "none" flag. It is used in INICIO (search from −1) and in ESCRIBE.
- Everything else lives in a single FSM module.

## Test plan
- Defaults, `bypass`=000, one `datolisto` pulse:
  - `resultadolisto` at cycle 47;
  - `hist_we` ×6, `out_we` ×2 (cycles 23 and 46);
  - `coef_addr` sequence 0–4, 5–9, 10–14 per channel.
- `bypass`=010:
  - L=33;
  - `coef_addr` never in 5–9;
  - `sec` goes 0→2.
- `bypass`=111, `NUM_CHANNELS`=2:
  - `ld_cur`/`out_we` pairs only;
  - `resultadolisto` at cycle 5;
  - no `acc_en`.
- `datolisto` pulsed at cycle 10 and again in the RESULT cycle:
  - `overrun`=1 after the first pulse;
  - neither sample is accepted;
  - `clr_overrun` clears the flag;
  - simultaneous set and clear leaves `overrun`=1.
- `reset` asserted in MAC of channel 1:
  - all outputs 0 on the next cycle, state ESPERA;
  - a fresh `datolisto` yields a full L=47 run.
- `NUM_SECTIONS`=1, `NUM_CHANNELS`=1:
  - L=10;
  - `coef_addr` 0–4;
  - `sec` and `ch` held at 0.
